// File: rtl/axis_cmd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : axis_cmd_scheduler_pkg
// Desc   : Shared types/constants for the axis command scheduler.
//          STALE_ZERO_EN: stale slots send zero pulses instead of repeating.
// Rev    : 1.0
// ============================================================================
package axis_cmd_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int DIR_BIT      = 7;
    localparam int CNT_MSB      = 6;
    localparam int PERIOD_CNT_W = 15;

    // Command sent to an axis whose host update missed its slot.
    function automatic logic [7:0] stale_cmd(input logic [7:0] last_cmd);
`ifdef STALE_ZERO_EN
        return {last_cmd[DIR_BIT], {(CNT_MSB+1){1'b0}}};
`else
        return last_cmd;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_cmd_scheduler_period_timer.sv
`default_nettype none
// ============================================================================
// Module : axis_cmd_scheduler_period_timer
// Desc   : Free-running control-period counter with enable and period tick.
// Rev    : 1.0
// ============================================================================
module axis_cmd_scheduler_period_timer
    import axis_cmd_scheduler_pkg::*;
#(
    parameter int PERIOD_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [PERIOD_CNT_W-1:0] CNT_LAST = PERIOD_CNT_W'(PERIOD_CYCLES - 1);

    logic [PERIOD_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == CNT_LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/axis_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module : axis_cmd_scheduler
// Desc   : Buffers one host command per axis and loads the generators over a
//          shared N bus once per period. Option macro: STALE_ZERO_EN.
// Rev    : 1.0
// ============================================================================
module axis_cmd_scheduler
    import axis_cmd_scheduler_pkg::*;
#(
    parameter int NAXIS         = 4,
    parameter int PERIOD_CYCLES = 20000,
    parameter int SETUP_CYCLES  = 2,
    parameter int WR_CYCLES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             host_wr,
    input  logic [2:0]       host_axis,
    input  logic [7:0]       host_data,
    input  logic             host_clr,
    input  logic [NAXIS-1:0] gen_busy,
    output logic [7:0]       n_bus,
    output logic [NAXIS-1:0] gen_wr,
    output logic             period_tick,
    output logic             seq_active,
    output logic [NAXIS-1:0] stale,
    output logic [NAXIS-1:0] overrun
);

    localparam logic [7:0] S_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] W_LAST  = 8'(WR_CYCLES - 1);
    localparam logic [2:0] AX_LAST = 3'(NAXIS - 1);

    logic             tick;
    state_t           state, state_nxt;
    logic [2:0]       ax, ax_nxt;
    logic [7:0]       cyc, cyc_nxt;
    logic             load;
    logic [7:0]       shadow [NAXIS];
    logic [7:0]       last   [NAXIS];
    logic [NAXIS-1:0] pend;
    logic [NAXIS-1:0] hit, slot, wr_nxt;
    logic [7:0]       sel_shadow, sel_last;
    logic             sel_pend;

    axis_cmd_scheduler_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    assign period_tick = tick;
    assign seq_active  = (state != IDLE);

    // load marks the edge that enters SETUP for axis ax_nxt.
    always_comb begin
        state_nxt = state;
        ax_nxt    = ax;
        cyc_nxt   = cyc;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SETUP;
                    ax_nxt    = 3'd0;
                    cyc_nxt   = 8'd0;
                    load      = 1'b1;
                end
            end
            SETUP: begin
                if (cyc == S_LAST) begin
                    state_nxt = STROBE;
                    cyc_nxt   = 8'd0;
                end else begin
                    cyc_nxt = cyc + 8'd1;
                end
            end
            STROBE: begin
                if (cyc == W_LAST) begin
                    state_nxt = GAP;
                    cyc_nxt   = 8'd0;
                end else begin
                    cyc_nxt = cyc + 8'd1;
                end
            end
            GAP: begin
                if (ax == AX_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SETUP;
                    ax_nxt    = ax + 3'd1;
                    load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_shadow = 8'd0;
        sel_last   = 8'd0;
        sel_pend   = 1'b0;
        hit        = '0;
        slot       = '0;
        wr_nxt     = '0;
        for (int i = 0; i < NAXIS; i++) begin
            hit[i]    = host_wr && (host_axis == 3'(i));
            slot[i]   = load && (ax_nxt == 3'(i));
            wr_nxt[i] = (state_nxt == STROBE) && (ax_nxt == 3'(i));
            if (ax_nxt == 3'(i)) begin
                sel_shadow = shadow[i];
                sel_last   = last[i];
                sel_pend   = pend[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ax     <= 3'd0;
            cyc    <= 8'd0;
            n_bus  <= 8'd0;
            gen_wr <= '0;
        end else begin
            state  <= state_nxt;
            ax     <= ax_nxt;
            cyc    <= cyc_nxt;
            gen_wr <= wr_nxt;
            if (load) begin
                n_bus <= sel_pend ? sel_shadow : stale_cmd(sel_last);
            end
        end
    end

    // A host write in the slot's load cycle keeps pend set: it targets the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            stale   <= '0;
            overrun <= '0;
            for (int i = 0; i < NAXIS; i++) begin
                shadow[i] <= 8'd0;
                last[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NAXIS; i++) begin
                if (hit[i]) begin
                    shadow[i] <= host_data;
                end
                if (hit[i]) begin
                    pend[i] <= 1'b1;
                end else if (slot[i]) begin
                    pend[i] <= 1'b0;
                end
                if (slot[i]) begin
                    last[i] <= pend[i] ? shadow[i] : stale_cmd(last[i]);
                end
                if (slot[i] && !pend[i]) begin
                    stale[i] <= 1'b1;
                end else if (host_clr) begin
                    stale[i] <= 1'b0;
                end
                if (slot[i] && gen_busy[i]) begin
                    overrun[i] <= 1'b1;
                end else if (host_clr) begin
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

    a_tick_only_in_idle: assert property (
        @(posedge clk) disable iff (!rst_n) tick |-> (state == IDLE)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_cmd_scheduler
// Desc   : Directed bench with an offset-based reference model of the schedule.
// Rev    : 1.0
// ============================================================================
module tb_axis_cmd_scheduler;

    localparam int NA   = 4;
    localparam int P    = 100;
    localparam int S    = 2;
    localparam int W    = 2;
    localparam int SLOT = S + W + 1;
    localparam int SEQ  = NA * SLOT;
`ifdef STALE_ZERO_EN
    localparam logic [7:0] B0_STALE = 8'h80;
`else
    localparam logic [7:0] B0_STALE = 8'hB0;
`endif

    logic          clk, rst_n, enable, host_wr, host_clr;
    logic [2:0]    host_axis;
    logic [7:0]    host_data, n_bus;
    logic [NA-1:0] gen_busy, gen_wr, stale, overrun;
    logic          period_tick, seq_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    axis_cmd_scheduler #(
        .NAXIS(NA), .PERIOD_CYCLES(P), .SETUP_CYCLES(S), .WR_CYCLES(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .host_wr(host_wr),
        .host_axis(host_axis), .host_data(host_data), .host_clr(host_clr),
        .gen_busy(gen_busy), .n_bus(n_bus), .gen_wr(gen_wr),
        .period_tick(period_tick), .seq_active(seq_active),
        .stale(stale), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] stale_val(input logic [7:0] l);
`ifdef STALE_ZERO_EN
        return {l[7], 7'd0};
`else
        return l;
`endif
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: m_off is the position within the load sequence (0 = not running).
    int            m_cnt, m_off, m_a, m_hi;
    bit            m_t;
    logic [7:0]    m_sh [NA];
    logic [7:0]    m_last [NA];
    bit            m_pend [NA];
    logic [7:0]    e_nbus;
    logic [NA-1:0] e_stale, e_ovr, e_wr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_off = 0; e_nbus = 8'd0; e_stale = '0; e_ovr = '0;
            for (int i = 0; i < NA; i++) begin
                m_sh[i] = 8'd0; m_last[i] = 8'd0; m_pend[i] = 1'b0;
            end
        end else begin
            m_t = enable && (m_cnt == P - 1);
            if (enable) m_cnt = (m_cnt + 1) % P;
            if (m_off != 0) m_off = (m_off == SEQ) ? 0 : m_off + 1;
            else if (m_t) m_off = 1;
            if (host_clr) begin
                e_stale = '0; e_ovr = '0;
            end
            if (m_off != 0 && ((m_off - 1) % SLOT) == 0) begin
                m_a = (m_off - 1) / SLOT;
                e_nbus = m_pend[m_a] ? m_sh[m_a] : stale_val(m_last[m_a]);
                if (!m_pend[m_a]) e_stale[m_a] = 1'b1;
                if (gen_busy[m_a]) e_ovr[m_a] = 1'b1;
                m_pend[m_a] = 1'b0;
                m_last[m_a] = e_nbus;
            end
            m_hi = int'(host_axis);
            if (host_wr && m_hi < NA) begin
                m_sh[m_hi] = host_data; m_pend[m_hi] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            e_wr = '0;
            if (m_off != 0 && ((m_off - 1) % SLOT) >= S && ((m_off - 1) % SLOT) < S + W)
                e_wr[(m_off - 1) / SLOT] = 1'b1;
            cmp("m_n_bus", 32'(n_bus), 32'(e_nbus));
            cmp("m_gen_wr", 32'(gen_wr), 32'(e_wr));
            cmp("m_tick", 32'(period_tick), 32'(enable && (m_cnt == P - 1)));
            cmp("m_seq_active", 32'(seq_active), 32'(m_off != 0));
            cmp("m_stale", 32'(stale), 32'(e_stale));
            cmp("m_overrun", 32'(overrun), 32'(e_ovr));
        end
    end

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        host_wr = 1'b1; host_axis = a; host_data = d;
        @(negedge clk);
        host_wr = 1'b0;
    endtask

    task automatic wait_tick(output int t);
        int n;
        n = 0;
        t = -1;
        while (n < 3 * P) begin
            @(posedge clk); #1;
            n++;
            if (period_tick) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL wait_tick: got no tick expected one within %0d cycles", 3 * P);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    int t, tk, c0;

    initial begin
        rst_n = 1'b0; enable = 1'b0; host_wr = 1'b0; host_axis = 3'd0;
        host_data = 8'd0; host_clr = 1'b0; gen_busy = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_n_bus", 32'(n_bus), 0);
        cmp("rst_gen_wr", 32'(gen_wr), 0);
        cmp("rst_tick", 32'(period_tick), 0);
        cmp("rst_seq", 32'(seq_active), 0);
        cmp("rst_stale", 32'(stale), 0);
        cmp("rst_overrun", 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b1; c0 = cyc;

        // Period 1: all axes written; bus timing.
        host_write(3'd0, 8'h85); host_write(3'd1, 8'h32);
        host_write(3'd2, 8'hB0); host_write(3'd3, 8'h07);
        wait_tick(t); tk = t;
        cmp("first_tick_cycle", 32'(t - c0), 32'(P - 1));
        at_cycle(tk + 1);  cmp("p1_nbus_ax0", 32'(n_bus), 32'h85); cmp("p1_seq_on", 32'(seq_active), 1);
        at_cycle(tk + 3);  cmp("p1_wr0_a", 32'(gen_wr), 32'b0001);
        at_cycle(tk + 4);  cmp("p1_wr0_b", 32'(gen_wr), 32'b0001);
        at_cycle(tk + 5);  cmp("p1_gap", 32'(gen_wr), 0);
        at_cycle(tk + 6);  cmp("p1_nbus_ax1", 32'(n_bus), 32'h32);
        at_cycle(tk + 8);  cmp("p1_wr1_a", 32'(gen_wr), 32'b0010);
        at_cycle(tk + 9);  cmp("p1_wr1_b", 32'(gen_wr), 32'b0010);
        at_cycle(tk + 20); cmp("p1_seq_last", 32'(seq_active), 1);
        at_cycle(tk + 21); cmp("p1_seq_off", 32'(seq_active), 0); cmp("p1_stale", 32'(stale), 0);

        // Period 2: axis2 stale, axis3 busy, out-of-range axis ignored.
        host_write(3'd0, 8'h01); host_write(3'd1, 8'h22);
        host_write(3'd3, 8'h03); host_write(3'd5, 8'hFF);
        @(negedge clk); gen_busy = 4'b1000;
        wait_tick(t); tk = t;
        at_cycle(tk + 11); cmp("p2_nbus_stale", 32'(n_bus), 32'(B0_STALE)); cmp("p2_stale", 32'(stale), 32'b0100);
        at_cycle(tk + 15); cmp("p2_ovr_before", 32'(overrun), 0);
        at_cycle(tk + 16); cmp("p2_ovr_set", 32'(overrun), 32'b1000);
        at_cycle(tk + 21);
        @(negedge clk); gen_busy = '0; host_clr = 1'b1;
        @(negedge clk); host_clr = 1'b0;
        at_cycle(cyc + 1); cmp("p2_clr_stale", 32'(stale), 0); cmp("p2_clr_ovr", 32'(overrun), 0);

        // Period 3: writes colliding with the slot; clear held while flags set.
        host_write(3'd1, 8'h22); host_write(3'd0, 8'h05); host_write(3'd3, 8'h06);
        wait_tick(t); tk = t;
        @(negedge clk); host_clr = 1'b1;
        at_cycle(tk + 6); host_write(3'd1, 8'h11);
        at_cycle(tk + 8);  cmp("p3_nbus_old", 32'(n_bus), 32'h22);
        at_cycle(tk + 10); host_write(3'd2, 8'h44);
        cmp("p3_stale_wins", 32'(stale), 32'b0100);
        at_cycle(tk + 12); cmp("p3_stale_cleared", 32'(stale), 0);
        at_cycle(tk + 21); @(negedge clk); host_clr = 1'b0;

        // Period 4: deferred writes delivered; reset during axis1 strobe.
        host_write(3'd0, 8'h0A); host_write(3'd3, 8'h0B);
        wait_tick(t); tk = t;
        at_cycle(tk + 6);  cmp("p4_nbus_new", 32'(n_bus), 32'h11);
        at_cycle(tk + 7);  cmp("p4_no_stale", 32'(stale), 0);
        at_cycle(tk + 8);  cmp("p4_wr1", 32'(gen_wr), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_gen_wr", 32'(gen_wr), 0);
        cmp("arst_n_bus", 32'(n_bus), 0);
        cmp("arst_seq", 32'(seq_active), 0);
        cmp("arst_flags", 32'({stale, overrun}), 0);
        @(negedge clk); rst_n = 1'b1; c0 = cyc;
        wait_tick(t); tk = t;
        cmp("tick_after_reset", 32'(t - c0), 32'(P - 1));

        // Enable low for 37 cycles delays the next tick by the same amount.
        repeat (30) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        host_write(3'd0, 8'h7F);
        repeat (25) @(negedge clk);
        enable = 1'b1;
        wait_tick(t);
        cmp("tick_delayed", 32'(t - tk), 32'(P + 37));
        at_cycle(t + 1);  cmp("p6_nbus_written_disabled", 32'(n_bus), 32'h7F);
        at_cycle(t + 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_cmd_scheduler.md
Name: axis_cmd_scheduler

Overview:
Per-period command scheduler for the axis pulse generators (8-bit N bus: bit7 = dir, bits6:0 = pulse count, rising-edge WR load, busy status).
- Generates the 1 ms control tick.
- Buffers one pending host command per axis.
- Shares a single N bus among NAXIS generators by strobing their individual WR lines in sequence, axis 0 first.
- Flags late host updates (stale) and generators still busy at reload (overrun).

Parameters:
NAXIS, 4, number of pulse generators served (2..8)
PERIOD_CYCLES, 20000, clk cycles per control period (1 ms at 20 MHz)
SETUP_CYCLES, 2, cycles N bus is stable before WR rises
WR_CYCLES, 2, cycles WR is held high (generator samples 0->1 edge, needs at least 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = run period timer and scheduling
host_wr  in  1  single-cycle command write strobe
host_axis  in  3  target axis index; values >= NAXIS are ignored
host_data  in  8  command byte (bit7 dir, bits6:0 count)
host_clr  in  1  clears sticky stale/overrun flags
gen_busy  in  NAXIS  busy outputs of the generators
n_bus  out  8  shared command bus to all generators
gen_wr  out  NAXIS  per-axis WR strobes
period_tick  out  1  one-cycle pulse at each period start
seq_active  out  1  high while the load sequence runs
stale  out  NAXIS  sticky: axis had no new command at its slot
overrun  out  NAXIS  sticky: gen_busy[i] was high at its slot

Behaviour:
- Reset values (async, rst_n = 0): n_bus = 0, gen_wr = 0, period_tick = 0, seq_active = 0, stale = 0, overrun = 0, period counter = 0, FSM = IDLE, all shadow registers = 0 and pending bits = 0. Reset mid-sequence aborts immediately; gen_wr drops in the same instant.
- Period counter: 15 bits, counts 0..PERIOD_CYCLES-1 while enable = 1, then wraps. period_tick = 1 in the cycle the counter equals PERIOD_CYCLES-1. With enable = 0 the counter holds, no tick is generated, and the host can still write.
- Host write: on host_wr, shadow[host_axis] <= host_data and pend[host_axis] <= 1. A later write before the slot overwrites (last write wins).
- FSM states:
  - IDLE: on period_tick, set ax = 0 and go to SETUP.
  - SETUP: on entry, n_bus <= pend[ax] ? shadow[ax] : last[ax]. If pend[ax] is 0, set stale[ax]. If gen_busy[ax] = 1, set overrun[ax]. Clear pend[ax] and update last[ax]. Stay SETUP_CYCLES cycles, then go to STROBE.
  - STROBE: gen_wr[ax] = 1 for WR_CYCLES cycles, then go to GAP.
  - GAP: 1 cycle with all WR low. If ax = NAXIS-1, go to IDLE; else ax++ and go to SETUP.
- Timing: the first SETUP cycle is tick+1. Axis i WR rises at tick+1+i*(S+W+1)+S. Total sequence length = NAXIS*(S+W+1) cycles (20 at defaults). seq_active is high in every non-IDLE cycle.
- Collisions:
  - host_wr to axis ax in its SETUP entry cycle: the latched value is the pre-write shadow; the new write remains pending for the next period.
  - host_clr together with a flag set: the set wins.
  - A tick while not IDLE cannot occur, because PERIOD_CYCLES > sequence length (checked by assertion).
- n_bus holds its last driven value in IDLE. At most one gen_wr bit is high at any time.

Optional Feature:
STALE_ZERO_EN — when defined, a stale slot drives {last[ax][7], 7'd0}: zero pulses, previous direction kept, so the axis stops. When undefined, a stale slot repeats last[ax] (the axis continues at its previous rate). The stale flag behaves identically in both cases.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, SETUP, STROBE, GAP)
  - Command byte field positions: DIR_BIT = 7, CNT_MSB = 6
  - Period counter width constant (15)
- One natural sub-module: period_timer (counter + enable + tick output), reusable by other control-loop blocks.

Test Plan:
- Host writes axis0 = 0x85, axis1 = 0x32, then a tick -> n_bus = 0x85 from tick+1; gen_wr[0] high at tick+3..tick+4; n_bus = 0x32 at tick+6; gen_wr[1] high at tick+8..+9; seq_active low after tick+20; stale = 0 for axes 0 and 1.
- No write to axis2 before a tick, with last[2] = 0xB0 -> stale[2] set; n_bus = 0xB0 (0x80 with STALE_ZERO_EN); host_clr clears the flag.
- gen_busy[3] held high through axis 3's SETUP -> overrun[3] set at tick+16; other overrun bits stay 0.
- host_wr to axis1 with 0x11 in axis 1's SETUP entry cycle, old shadow 0x22 -> this period sends 0x22; next period sends 0x11 with stale[1] = 0.
- rst_n asserted during STROBE of axis 1 -> gen_wr = 0 immediately and all outputs at reset values; after release, the first tick arrives PERIOD_CYCLES cycles later.
- enable low for 5000 cycles mid-period -> no tick; the tick arrives 5000 cycles later than the nominal 20000.
